// File: rtl/lspc_vram_cpu_port_if.sv
// CPU register bus plus VRAM write/acknowledge/read-back handshake signals
// exchanged between the 68k-side register port and the VRAM arbiters.
interface lspc_vram_cpu_port_if;
  logic        CPU_WR;
  logic        CPU_RD;
  logic [1:0]  CPU_REG;
  logic [15:0] CPU_DIN;
  logic [15:0] CPU_DOUT;
  logic        nCPU_WR_HIGH;
  logic        nCPU_WR_LOW;
  logic        RD_HIGH_STB;
  logic        RD_LOW_STB;
  logic [15:0] VRAM_HIGH_READ;
  logic [15:0] VRAM_LOW_READ;
  logic [15:0] VRAM_ADDR;
  logic [15:0] VRAM_WRITE;
  logic        REG_VRAMADDR_MSB;
  logic        nVRAM_WRITE_REQ;
  logic        RD_VALID;
  logic        OVERRUN;

  // The CPU port itself.
  modport slave (
    input  CPU_WR, CPU_RD, CPU_REG, CPU_DIN,
    input  nCPU_WR_HIGH, nCPU_WR_LOW, RD_HIGH_STB, RD_LOW_STB,
    input  VRAM_HIGH_READ, VRAM_LOW_READ,
    output CPU_DOUT, VRAM_ADDR, VRAM_WRITE, REG_VRAMADDR_MSB,
    output nVRAM_WRITE_REQ, RD_VALID, OVERRUN
  );

  // The 68k and the arbiters around the port.
  modport master (
    output CPU_WR, CPU_RD, CPU_REG, CPU_DIN,
    output nCPU_WR_HIGH, nCPU_WR_LOW, RD_HIGH_STB, RD_LOW_STB,
    output VRAM_HIGH_READ, VRAM_LOW_READ,
    input  CPU_DOUT, VRAM_ADDR, VRAM_WRITE, REG_VRAMADDR_MSB,
    input  nVRAM_WRITE_REQ, RD_VALID, OVERRUN
  );
endinterface

// File: rtl/lspc_vram_cpu_port.sv
// LSPC VRAM CPU port: VRAMADDR/VRAMMOD/VRAMRW registers, write request
// toward the fast (MSB=1) or slow (MSB=0) VRAM arbiter, post-write address
// modulo, a one-entry write buffer, a shadow address for writes that land
// while a request is in flight, and read-back capture.
module lspc_vram_cpu_port (
  input  logic                        CLK,
  input  logic                        RESET,
  lspc_vram_cpu_port_if.slave         bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] vram_addr_q, vram_addr_d;
  logic [15:0] vram_mod_q, vram_mod_d;
  logic [15:0] vram_write_q, vram_write_d;
  logic        nreq_q, nreq_d;
  logic        rd_valid_q, rd_valid_d;
  logic        overrun_q, overrun_d;
  logic [15:0] dout_q, dout_d;
  logic [15:0] rdlatch_q, rdlatch_d;
  logic        buf_full_q, buf_full_d;
  logic [15:0] buf_data_q, buf_data_d;
  logic        shadow_valid_q, shadow_valid_d;
  logic [15:0] shadow_q, shadow_d;
  logic        ack_hi_prev_q, ack_lo_prev_q;

  logic        wr_addr_s, wr_rw_s, wr_mod_s;
  logic        msb_s, ack_edge_s;

  assign wr_addr_s  = bus.CPU_WR && (bus.CPU_REG == 2'd0);
  assign wr_rw_s    = bus.CPU_WR && (bus.CPU_REG == 2'd1);
  assign wr_mod_s   = bus.CPU_WR && (bus.CPU_REG == 2'd2);
  assign msb_s      = vram_addr_q[15];
  // Only the acknowledge of the arbiter selected by the address MSB counts.
  assign ack_edge_s = msb_s ? (ack_hi_prev_q & ~bus.nCPU_WR_HIGH)
                            : (ack_lo_prev_q & ~bus.nCPU_WR_LOW);

  // Next-state and register update logic for the whole port.
  always_comb begin
    state_d        = state_q;
    vram_addr_d    = vram_addr_q;
    vram_mod_d     = vram_mod_q;
    vram_write_d   = vram_write_q;
    nreq_d         = nreq_q;
    rd_valid_d     = rd_valid_q;
    overrun_d      = overrun_q;
    dout_d         = dout_q;
    rdlatch_d      = rdlatch_q;
    buf_full_d     = buf_full_q;
    buf_data_d     = buf_data_q;
    shadow_valid_d = shadow_valid_q;
    shadow_d       = shadow_q;

    // Read-back capture; any address change below overrides RD_VALID.
    if (!rd_valid_q && msb_s && bus.RD_HIGH_STB) begin
      rdlatch_d  = bus.VRAM_HIGH_READ;
      rd_valid_d = 1'b1;
    end else if (!rd_valid_q && !msb_s && bus.RD_LOW_STB) begin
      rdlatch_d  = bus.VRAM_LOW_READ;
      rd_valid_d = 1'b1;
    end else begin
      rdlatch_d  = rdlatch_q;
    end

    if (wr_mod_s) begin
      vram_mod_d = bus.CPU_DIN;
    end else begin
      vram_mod_d = vram_mod_q;
    end

    if (bus.CPU_RD) begin
      case (bus.CPU_REG)
        2'd0:    dout_d = vram_addr_q;
        2'd1:    dout_d = rdlatch_q;
        2'd2:    dout_d = vram_mod_q;
        default: dout_d = 16'h0000;
      endcase
    end else begin
      dout_d = dout_q;
    end

    // VRAMRW writes while a request is busy go to the one-entry buffer.
    if (wr_rw_s && (state_q != S_IDLE)) begin
      if (buf_full_q) begin
        overrun_d = 1'b1;
      end else begin
        buf_full_d = 1'b1;
        buf_data_d = bus.CPU_DIN;
      end
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      S_IDLE: begin
        if (wr_rw_s) begin
          vram_write_d = bus.CPU_DIN;
          nreq_d       = 1'b0;
          state_d      = S_REQ;
        end else if (buf_full_q) begin
          vram_write_d = buf_data_q;
          buf_full_d   = 1'b0;
          nreq_d       = 1'b0;
          state_d      = S_REQ;
        end else begin
          state_d      = S_IDLE;
        end
        if (wr_addr_s) begin
          vram_addr_d = bus.CPU_DIN;
          rd_valid_d  = 1'b0;
        end else begin
          vram_addr_d = vram_addr_q;
        end
      end
      S_REQ: begin
        if (ack_edge_s) begin
          nreq_d     = 1'b1;
          rd_valid_d = 1'b0;
          state_d    = S_GAP;
          if (shadow_valid_q) begin
            vram_addr_d    = shadow_q;
            shadow_valid_d = 1'b0;
          end else begin
            vram_addr_d = {vram_addr_q[15], vram_addr_q[14:0] + vram_mod_q[14:0]};
          end
        end else begin
          state_d = S_REQ;
        end
        // The in-flight write keeps its address; a new one waits in the shadow.
        if (wr_addr_s) begin
          shadow_d       = bus.CPU_DIN;
          shadow_valid_d = 1'b1;
        end else begin
          shadow_d = shadow_q;
        end
      end
      S_GAP: begin
        if (buf_full_q) begin
          vram_write_d = buf_data_q;
          buf_full_d   = 1'b0;
          nreq_d       = 1'b0;
          state_d      = S_REQ;
        end else begin
          state_d      = S_IDLE;
        end
        if (wr_addr_s) begin
          vram_addr_d    = bus.CPU_DIN;
          shadow_valid_d = 1'b0;
          rd_valid_d     = 1'b0;
        end else if (shadow_valid_q) begin
          vram_addr_d    = shadow_q;
          shadow_valid_d = 1'b0;
          rd_valid_d     = 1'b0;
        end else begin
          vram_addr_d    = vram_addr_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        nreq_d  = 1'b1;
      end
    endcase
  end

  // State registers, acknowledge history and output flops.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= S_IDLE;
      vram_addr_q    <= 16'h0000;
      vram_mod_q     <= 16'h0000;
      vram_write_q   <= 16'h0000;
      nreq_q         <= 1'b1;
      rd_valid_q     <= 1'b0;
      overrun_q      <= 1'b0;
      dout_q         <= 16'h0000;
      rdlatch_q      <= 16'h0000;
      buf_full_q     <= 1'b0;
      buf_data_q     <= 16'h0000;
      shadow_valid_q <= 1'b0;
      shadow_q       <= 16'h0000;
      ack_hi_prev_q  <= 1'b1;
      ack_lo_prev_q  <= 1'b1;
    end else begin
      state_q        <= state_d;
      vram_addr_q    <= vram_addr_d;
      vram_mod_q     <= vram_mod_d;
      vram_write_q   <= vram_write_d;
      nreq_q         <= nreq_d;
      rd_valid_q     <= rd_valid_d;
      overrun_q      <= overrun_d;
      dout_q         <= dout_d;
      rdlatch_q      <= rdlatch_d;
      buf_full_q     <= buf_full_d;
      buf_data_q     <= buf_data_d;
      shadow_valid_q <= shadow_valid_d;
      shadow_q       <= shadow_d;
      ack_hi_prev_q  <= bus.nCPU_WR_HIGH;
      ack_lo_prev_q  <= bus.nCPU_WR_LOW;
    end
  end

  assign bus.CPU_DOUT         = dout_q;
  assign bus.VRAM_ADDR        = vram_addr_q;
  assign bus.VRAM_WRITE       = vram_write_q;
  assign bus.REG_VRAMADDR_MSB = vram_addr_q[15];
  assign bus.nVRAM_WRITE_REQ  = nreq_q;
  assign bus.RD_VALID         = rd_valid_q;
  assign bus.OVERRUN          = overrun_q;

endmodule
